// File: rtl/video_pkg.sv
// Shared definitions for the video pattern scheduler: colours, pattern codes, command ops, mode type.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package video_pkg;

    // Colours packed as {B,G,R}, 8 bits per channel
    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'h00FFFF;
    localparam logic [23:0] COL_CYAN    = 24'hFFFF00;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'h0000FF;
    localparam logic [23:0] COL_BLUE    = 24'hFF0000;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    localparam logic [2:0] PAT_BARS  = 3'd0;
    localparam logic [2:0] PAT_GRAD  = 3'd1;
    localparam logic [2:0] PAT_CHECK = 3'd2;
    localparam logic [2:0] PAT_RED   = 3'd3;
    localparam logic [2:0] PAT_GREEN = 3'd4;
    localparam logic [2:0] PAT_BLUE  = 3'd5;
    localparam logic [2:0] PAT_WHITE = 3'd6;
    localparam logic [2:0] PAT_BLACK = 3'd7;

    localparam logic [1:0] OP_AUTO = 2'd0;
    localparam logic [1:0] OP_HOLD = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    typedef enum logic {
        MODE_AUTO = 1'b0,
        MODE_HOLD = 1'b1
    } mode_e;

    // Colour-bar lookup, left (0) to right (7)
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Pixel colour generator: bar counter, pattern mux, blanking (+ optional border, VIDEO_SCHED_BORDER_EN).
// Latency: 1 cycle from hor_cnt/ver_cnt to color_data.
// No backpressure: one pixel per clock, always.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] hor_cnt,
    input  logic [11:0] ver_cnt,
    input  logic [2:0]  pattern,
    output logic [23:0] color_data
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int PIX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(BAR_W - 1);
    localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

    logic [2:0]       bar_q,   bar_d;
    logic [PIX_W-1:0] pix_q,   pix_d;
    logic [23:0]      color_q, color_d;

    // Bar index for the current pixel: restart at line start, step every BAR_W pixels, stop at 7
    always_comb begin
        bar_d = bar_q;
        pix_d = pix_q;
        if (hor_cnt == 12'd0) begin
            bar_d = 3'd0;
            pix_d = '0;
        end else if (pix_q == PIX_LAST) begin
            pix_d = '0;
            if (bar_q != 3'd7) begin
                bar_d = bar_q + 3'd1;
            end
        end else begin
            pix_d = pix_q + 1'b1;
        end
    end

    // Colour select; blanking outside the active area wins over everything
    always_comb begin
        color_d = COL_BLACK;
        case (pattern)
            PAT_BARS:  color_d = bar_color(bar_d);
            PAT_GRAD:  color_d = {3{hor_cnt[7:0]}};
            PAT_CHECK: color_d = (hor_cnt[5] ^ ver_cnt[5]) ? COL_WHITE : COL_BLACK;
            PAT_RED:   color_d = COL_RED;
            PAT_GREEN: color_d = COL_GREEN;
            PAT_BLUE:  color_d = COL_BLUE;
            PAT_WHITE: color_d = COL_WHITE;
            default:   color_d = COL_BLACK;
        endcase
`ifdef VIDEO_SCHED_BORDER_EN
        if (hor_cnt == 12'd0 || hor_cnt == H_LIM - 12'd1 ||
            ver_cnt == 12'd0 || ver_cnt == V_LIM - 12'd1) begin
            color_d = COL_WHITE;
        end
`endif
        if (hor_cnt >= H_LIM || ver_cnt >= V_LIM) begin
            color_d = COL_BLACK;
        end
    end

    // Bar tracking state and registered pixel output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_q   <= 3'd0;
            pix_q   <= '0;
            color_q <= COL_BLACK;
        end else begin
            bar_q   <= bar_d;
            pix_q   <= pix_d;
            color_q <= color_d;
        end
    end

    assign color_data = color_q;

endmodule

// File: rtl/video_pattern_scheduler.sv
// Test-pattern scheduler: AUTO/HOLD mode FSM, frame counter, command handshake, pattern generator.
// Latency: colour 1 cycle after counters; frame_start 1 cycle after (0,0); commands apply on frame_start.
// Backpressure: one-entry pending slot; O_cmd_ready low until the pending command is applied.
module video_pattern_scheduler
    import video_pkg::*;
#(
    parameter int H_ACTIVE           = 1280,
    parameter int V_ACTIVE           = 720,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [11:0] I_hor_cnt,
    input  logic [11:0] I_ver_cnt,
    input  logic        I_cmd_valid,
    output logic        O_cmd_ready,
    input  logic [1:0]  I_cmd_op,
    input  logic [2:0]  I_cmd_arg,
    output logic [23:0] O_color_data,
    output logic [2:0]  O_pattern,
    output logic        O_frame_start,
    output logic        O_hold
);

    localparam logic [15:0] FC_LAST = 16'(FRAMES_PER_PATTERN - 1);

    mode_e       mode_q,     mode_d;
    logic [2:0]  pattern_q,  pattern_d;
    logic [15:0] fc_q,       fc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [1:0]  pend_op_q,  pend_op_d;
    logic [2:0]  pend_arg_q, pend_arg_d;
    logic        zero_q,     zero_d;
    logic        fs_q,       fs_d;
    logic        cmd_apply;

    // Frame-start edge detect: pulse only on the first (0,0) sample of a run
    always_comb begin
        zero_d = (I_hor_cnt == 12'd0) && (I_ver_cnt == 12'd0);
        fs_d   = zero_d && !zero_q;
    end

    // Mode FSM, frame counter and pending slot; all changes land on frame_start only
    always_comb begin
        mode_d     = mode_q;
        pattern_d  = pattern_q;
        fc_d       = fc_q;
        pend_vld_d = pend_vld_q;
        pend_op_d  = pend_op_q;
        pend_arg_d = pend_arg_q;
        cmd_apply  = fs_q && pend_vld_q && (pend_op_q != OP_RSVD);

        if (I_cmd_valid && !pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_op_d  = I_cmd_op;
            pend_arg_d = I_cmd_arg;
        end

        // A reserved op is consumed here but leaves normal auto-advance untouched
        if (fs_q && pend_vld_q) begin
            pend_vld_d = 1'b0;
        end

        if (cmd_apply) begin
            // Command wins over a same-frame rollover
            case (pend_op_q)
                OP_AUTO: begin
                    mode_d = MODE_AUTO;
                    fc_d   = 16'd0;
                end
                OP_HOLD: begin
                    mode_d    = MODE_HOLD;
                    pattern_d = pend_arg_q;
                end
                OP_STEP: begin
                    pattern_d = pattern_q + 3'd1;
                    fc_d      = 16'd0;
                end
                default: ;
            endcase
        end else if (fs_q && mode_q == MODE_AUTO) begin
            if (fc_q == FC_LAST) begin
                pattern_d = pattern_q + 3'd1;
                fc_d      = 16'd0;
            end else begin
                fc_d = fc_q + 16'd1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mode_q     <= MODE_AUTO;
            pattern_q  <= PAT_BARS;
            fc_q       <= 16'd0;
            pend_vld_q <= 1'b0;
            pend_op_q  <= OP_AUTO;
            pend_arg_q <= 3'd0;
            zero_q     <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            fc_q       <= fc_d;
            pend_vld_q <= pend_vld_d;
            pend_op_q  <= pend_op_d;
            pend_arg_q <= pend_arg_d;
            zero_q     <= zero_d;
            fs_q       <= fs_d;
        end
    end

    assign O_cmd_ready   = !pend_vld_q;
    assign O_frame_start = fs_q;
    assign O_pattern     = pattern_q;
    assign O_hold        = (mode_q == MODE_HOLD);

    video_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_gen (
        .clk        (I_clk),
        .rst_n      (I_rst_n),
        .hor_cnt    (I_hor_cnt),
        .ver_cnt    (I_ver_cnt),
        .pattern    (pattern_q),
        .color_data (O_color_data)
    );

endmodule

// File: tb/tb_video_pattern_scheduler.sv
// Directed bench for video_pattern_scheduler with FRAMES_PER_PATTERN=2.
// Frames are synthesised cheaply: a (0,0) sample marks each frame start.
// Expected values are hand-derived constants.
module tb_video_pattern_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] hor = 12'd100;
    logic [11:0] ver = 12'd100;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [2:0]  cmd_arg = 3'd0;
    logic [23:0] color;
    logic [2:0]  pattern;
    logic        frame_start;
    logic        hold;

    int checks = 0;
    int errors = 0;

    video_pattern_scheduler #(
        .H_ACTIVE           (1280),
        .V_ACTIVE           (720),
        .FRAMES_PER_PATTERN (2)
    ) dut (
        .I_clk         (clk),
        .I_rst_n       (rst_n),
        .I_hor_cnt     (hor),
        .I_ver_cnt     (ver),
        .I_cmd_valid   (cmd_valid),
        .O_cmd_ready   (cmd_ready),
        .I_cmd_op      (cmd_op),
        .I_cmd_arg     (cmd_arg),
        .O_color_data  (color),
        .O_pattern     (pattern),
        .O_frame_start (frame_start),
        .O_hold        (hold)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One short frame: (0,0) held two samples, then a few non-origin pixels
    task automatic run_frame(output logic [2:0] pat_at_fs, output int pulses);
        pulses = 0;
        hor = 12'd0; ver = 12'd0;
        tick();
        pat_at_fs = pattern;
        pulses += int'(frame_start);
        tick();
        pulses += int'(frame_start);
        hor = 12'd1;
        tick();
        pulses += int'(frame_start);
        hor = 12'd7; ver = 12'd3;
        tick();
        pulses += int'(frame_start);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] arg);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] p;
        int n;

        // Reset values while held in reset
        #3;
        check("rst_color", color, 24'h0);
        check("rst_pattern", {21'd0, pattern}, 24'd0);
        check("rst_fs", {23'd0, frame_start}, 24'd0);
        check("rst_hold", {23'd0, hold}, 24'd0);
        check("rst_ready", {23'd0, cmd_ready}, 24'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // AUTO with 2 frames per pattern: pattern at frame starts 0,0,1
        run_frame(p, n); check("auto_f0_pat", {21'd0, p}, 24'd0); check("auto_f0_pulses", 24'(n), 24'd1);
        run_frame(p, n); check("auto_f1_pat", {21'd0, p}, 24'd0); check("auto_f1_pulses", 24'(n), 24'd1);
        run_frame(p, n); check("auto_f2_pat", {21'd0, p}, 24'd1); check("auto_f2_pulses", 24'(n), 24'd1);

        // HOLD 0 for the colour-bar sweep
        issue(2'd1, 3'd0);
        check("hold0_ready_low", {23'd0, cmd_ready}, 24'd0);
        run_frame(p, n);
        check("hold0_pattern", {21'd0, pattern}, 24'd0);
        check("hold0_hold", {23'd0, hold}, 24'd1);
        check("hold0_ready_high", {23'd0, cmd_ready}, 24'd1);

        ver = 12'd10;
        for (int h = 0; h < 1280; h++) begin
            hor = 12'(h);
            tick();
            if (h == 0)   check("bar_h0", color, 24'hFFFFFF);
            if (h == 159) check("bar_h159", color, 24'hFFFFFF);
            if (h == 160) check("bar_h160", color, 24'h00FFFF);
`ifdef VIDEO_SCHED_BORDER_EN
            if (h == 1279) check("bar_h1279", color, 24'hFFFFFF);
`else
            if (h == 1279) check("bar_h1279", color, 24'h000000);
`endif
        end
        hor = 12'd1280; ver = 12'd10;
        tick();
        check("blank_h1280", color, 24'h0);
        hor = 12'd10; ver = 12'd720;
        tick();
        check("blank_v720", color, 24'h0);

        // Checkerboard
        issue(2'd1, 3'd2);
        run_frame(p, n);
        hor = 12'd32; ver = 12'd0;  tick(); check("chk_32_0", color, 24'hFFFFFF);
        hor = 12'd32; ver = 12'd32; tick(); check("chk_32_32", color, 24'h000000);
        hor = 12'd64; ver = 12'd32; tick(); check("chk_64_32", color, 24'hFFFFFF);

        // HOLD 5 issued mid-frame
        hor = 12'd50; ver = 12'd50;
        issue(2'd1, 3'd5);
        check("h5_ready_low0", {23'd0, cmd_ready}, 24'd0);
        tick(); tick(); tick();
        check("h5_ready_low3", {23'd0, cmd_ready}, 24'd0);
        run_frame(p, n);
        check("h5_pat_at_fs", {21'd0, p}, 24'd2);
        check("h5_pattern", {21'd0, pattern}, 24'd5);
        check("h5_hold", {23'd0, hold}, 24'd1);
        check("h5_ready_high", {23'd0, cmd_ready}, 24'd1);
        hor = 12'd10; ver = 12'd10; tick();
        check("h5_color", color, 24'hFF0000);
        for (int f = 0; f < 10; f++) run_frame(p, n);
        check("h5_after10", {21'd0, pattern}, 24'd5);

        // Gradient and left-edge pixel
        issue(2'd1, 3'd1);
        run_frame(p, n);
        hor = 12'h123; ver = 12'd3; tick();
        check("grad_123", color, 24'h232323);
        hor = 12'd0; ver = 12'd100; tick();
`ifdef VIDEO_SCHED_BORDER_EN
        check("border_h0", color, 24'hFFFFFF);
`else
        check("edge_h0", color, 24'h000000);
`endif

        // STEP on the rollover frame at pattern 7
        issue(2'd1, 3'd7); run_frame(p, n);
        issue(2'd0, 3'd0); run_frame(p, n);
        check("auto_pat7", {21'd0, pattern}, 24'd7);
        check("auto_hold0", {23'd0, hold}, 24'd0);
        run_frame(p, n);
        check("auto_fc1_pat7", {21'd0, pattern}, 24'd7);
        issue(2'd2, 3'd0); run_frame(p, n);
        check("step_wrap", {21'd0, pattern}, 24'd0);
        run_frame(p, n);
        check("step_fc_cleared", {21'd0, pattern}, 24'd0);
        run_frame(p, n);
        check("step_next_roll", {21'd0, pattern}, 24'd1);

        // Reset with a command pending
        hor = 12'd50; ver = 12'd50;
        issue(2'd1, 3'd3);
        check("prst_ready_low", {23'd0, cmd_ready}, 24'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_color", color, 24'h0);
        check("arst_pattern", {21'd0, pattern}, 24'd0);
        check("arst_fs", {23'd0, frame_start}, 24'd0);
        check("arst_hold", {23'd0, hold}, 24'd0);
        check("arst_ready", {23'd0, cmd_ready}, 24'd1);
        tick();
        rst_n = 1'b1;
        run_frame(p, n);
        check("prst_pat_f0", {21'd0, pattern}, 24'd0);
        check("prst_hold_f0", {23'd0, hold}, 24'd0);
        run_frame(p, n);
        check("prst_pat_f1", {21'd0, pattern}, 24'd1);
        check("prst_hold_f1", {23'd0, hold}, 24'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_pattern_scheduler.md
VIDEO_PATTERN_SCHEDULER -- requirements
Module: video_pattern_scheduler

Interface
REQ-001 Parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 Parameter FRAMES_PER_PATTERN, default 60, frames each pattern is shown in AUTO mode (legal 1..65535).
REQ-004 I_clk  in  1  pixel clock; all logic on rising edge.
REQ-005 I_rst_n  in  1  asynchronous, active-low reset.
REQ-006 I_hor_cnt  in  12  horizontal pixel counter from the video controller.
REQ-007 I_ver_cnt  in  12  vertical line counter from the video controller.
REQ-008 I_cmd_valid  in  1  command offered.
REQ-009 O_cmd_ready  out  1  command can be accepted.
REQ-010 I_cmd_op  in  2  0=AUTO, 1=HOLD, 2=STEP, 3=reserved (accepted, ignored).
REQ-011 I_cmd_arg  in  3  pattern index for HOLD.
REQ-012 O_color_data  out  24  pixel colour {B,G,R}, 8 bits each, to the video controller.
REQ-013 O_pattern  out  3  pattern currently displayed.
REQ-014 O_frame_start  out  1  one-cycle pulse per frame.
REQ-015 O_hold  out  1  high in HOLD mode.

Function
REQ-016 Patterns: 0 = eight vertical bars WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK, each H_ACTIVE/8 pixels wide, left to right; 1 = horizontal gradient R=G=B=I_hor_cnt[7:0]; 2 = checkerboard, WHITE when I_hor_cnt[5]^I_ver_cnt[5], else BLACK; 3 = RED; 4 = GREEN; 5 = BLUE; 6 = WHITE; 7 = BLACK.
REQ-017 Bar index comes from a counter cleared at I_hor_cnt==0 and incremented every H_ACTIVE/8 pixels, saturating at 7; no divider.
REQ-018 O_color_data is registered, one cycle of latency from I_hor_cnt/I_ver_cnt.
REQ-019 Pixels with I_hor_cnt>=H_ACTIVE or I_ver_cnt>=V_ACTIVE output 24'h000000.
REQ-020 O_frame_start pulses for one cycle, one cycle after the sample where I_hor_cnt==0 and I_ver_cnt==0; it is edge-detected, so one pulse per frame.
REQ-021 Mode FSM states: AUTO, HOLD. Reset state is AUTO.
REQ-022 Handshake: a command is accepted when I_cmd_valid && O_cmd_ready. The accepted op and arg go into a one-entry pending register, and O_cmd_ready drops on the next cycle.
REQ-023 A pending command is applied on the O_frame_start cycle, then O_cmd_ready rises again on the following cycle. Pattern and mode never change mid-frame.
REQ-024 AUTO command: state goes to AUTO, frame counter clears, pattern is unchanged.
REQ-025 HOLD command: state goes to HOLD, pattern becomes I_cmd_arg.
REQ-026 STEP command: pattern increments modulo 8, frame counter clears, state is unchanged.
REQ-027 In AUTO, a 16-bit frame counter increments on each O_frame_start. When it reaches FRAMES_PER_PATTERN-1, the pattern increments modulo 8 (7 wraps to 0) and the counter clears.
REQ-028 In HOLD, the frame counter is frozen.
REQ-029 If a pending command is applied on the same frame as an AUTO rollover, the command wins and the rollover is discarded.
REQ-030 I_cmd_valid while O_cmd_ready is low is ignored. The requester holds valid and retries.

Reset
REQ-031 On I_rst_n low, asynchronously: O_color_data=0, O_pattern=0, O_frame_start=0, O_hold=0, O_cmd_ready=1, state=AUTO, frame counter=0, pending register cleared, bar counter=0.
REQ-032 Reset mid-frame or with a command pending discards the pending command. Output resumes at the first sample after release.

Configuration
REQ-033 Macro VIDEO_SCHED_BORDER_EN defined: the 1-pixel perimeter of the active area (hor 0, hor H_ACTIVE-1, ver 0, ver V_ACTIVE-1) outputs WHITE, overriding the pattern, with the same latency.
REQ-034 Macro VIDEO_SCHED_BORDER_EN undefined: no border logic is present and the pattern covers the full active area.

Structure
REQ-035 Shared package video_pkg holds: colour constants WHITE..BLACK in {B,G,R} order, the 3-bit pattern encodings, the 2-bit command op encodings, and the mode state type.
REQ-036 One sub-module, video_pattern_gen, holds the bar counter and the pattern/colour mux plus the output register. The FSM, frame counter and handshake stay in the top.

Verification
REQ-037 Reset released, FRAMES_PER_PATTERN=2, counters sweep 3 frames -> O_pattern 0,0 then 1 at the start of frame 2; exactly one O_frame_start per frame.
REQ-038 Pattern 0, hor=0/159/160/1279, ver=10 -> colour 1 cycle later = WHITE, WHITE, YELLOW, BLACK (border macro off).
REQ-039 HOLD arg 5 issued mid-frame -> O_cmd_ready low until the next O_frame_start, then O_pattern=5 and O_hold=1; after 10 more frames O_pattern is still 5.
REQ-040 STEP issued on the cycle the rollover would fire, pattern 7 -> O_pattern=0 (wraps once, not twice), frame counter=0.
REQ-041 hor=1280 or ver=720 -> 24'h000000. With VIDEO_SCHED_BORDER_EN: hor=0, ver=100 -> 24'hFFFFFF.
REQ-042 Reset asserted with a command pending -> all outputs at their reset values immediately, O_cmd_ready=1, and the command is never applied.
